// File: rtl/jtag_dbg_pkg.sv
// rtl/jtag_dbg_pkg.sv - shared types and constants for the JTAG debug APB bridge
package jtag_dbg_pkg;

  localparam logic [4:0] IR_DEBUG_INSTR = 5'h12;

  typedef enum logic [3:0] {
    CMD_NOP       = 4'h0,
    CMD_SET_ADDR  = 4'h1,
    CMD_READ      = 4'h2,
    CMD_WRITE     = 4'h3,
    CMD_GET_RDATA = 4'h4,
    CMD_CLR_ERR   = 4'h5
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_WDATA = 2'd1,
    ST_SETUP      = 2'd2,
    ST_ACCESS     = 2'd3
  } bridge_state_e;

  localparam int STAT_BUSY     = 31;
  localparam int STAT_RD_VALID = 30;
  localparam int STAT_ERR_SLV  = 29;
  localparam int STAT_ERR_CMD  = 28;
  localparam int STAT_ERR_TMO  = 27;
  localparam int STAT_FSM_LSB  = 1;
  localparam int STAT_PEND_WR  = 0;

endpackage

// File: rtl/jtag_dbg_apb_bridge_if.sv
// rtl/jtag_dbg_apb_bridge_if.sv - TAP-side and APB-side signals of the debug bridge
interface jtag_dbg_apb_bridge_if #(
  parameter int IR_WIDTH   = 5,
  parameter int ADDR_WIDTH = 30
);
  logic [IR_WIDTH-1:0]   ir_i;
  logic                  ir_valid_i;
  logic [31:0]           dr_i;
  logic                  dr_valid_i;
  logic                  dr_done_i;
  logic [31:0]           dr_in_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [31:0]           pwdata_o;
  logic [31:0]           prdata_i;
  logic                  pready_i;
  logic                  pslverr_i;

  // master: the bridge itself (TAP consumer, APB master)
  modport master (
    input  ir_i, ir_valid_i, dr_i, dr_valid_i, dr_done_i,
    output dr_in_o,
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
    input  prdata_i, pready_i, pslverr_i
  );

  modport slave (
    output ir_i, ir_valid_i, dr_i, dr_valid_i, dr_done_i,
    input  dr_in_o,
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
    output prdata_i, pready_i, pslverr_i
  );
endinterface

// File: rtl/jtag_dbg_apb_bridge.sv
// rtl/jtag_dbg_apb_bridge.sv - decodes DEBUG-IR DR scans into APB master transfers
module jtag_dbg_apb_bridge
  import jtag_dbg_pkg::*;
#(
  parameter int                  IR_WIDTH       = 5,
  parameter logic [IR_WIDTH-1:0] IR_DEBUG       = IR_WIDTH'(IR_DEBUG_INSTR),
  parameter int                  ADDR_WIDTH     = 30,
  parameter int                  TIMEOUT_CYCLES = 1024
) (
  input logic                   clk_i,
  input logic                   trst_sync,
  jtag_dbg_apb_bridge_if.master bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bridge_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic [31:0]           cmd_word_q, cmd_word_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic inc_q, inc_d, rd_valid_q, rd_valid_d, sel_rdata_q, sel_rdata_d;
  logic err_slv_q, err_slv_d, err_cmd_q, err_cmd_d, err_tmo_q, err_tmo_d;
  logic ev_prev_q, ev_prev_d, ev_q, ev_d;
  logic    ev_raw;
  cmd_e    cmd;
  logic [31:0] status;

  assign ev_raw = bus.dr_done_i & bus.dr_valid_i;
  assign cmd    = cmd_e'(cmd_word_q[31:28]);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    pwdata_d    = pwdata_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    inc_d       = inc_q;
    rd_valid_d  = rd_valid_q;
    sel_rdata_d = sel_rdata_q;
    err_slv_d   = err_slv_q;
    err_cmd_d   = err_cmd_q;
    err_tmo_d   = err_tmo_q;
    // Event is edge-detected and registered together with the scanned word
    ev_prev_d   = ev_raw;
    ev_d        = ev_raw & ~ev_prev_q;
    cmd_word_d  = ev_d ? bus.dr_i : cmd_word_q;

    // Any finished scan ends the one that may have returned rdata_q
    if (ev_q) sel_rdata_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ev_q) begin
          case (cmd)
            CMD_NOP: ;
            CMD_SET_ADDR: addr_d = {cmd_word_q[ADDR_WIDTH-3:0], 2'b00};
            CMD_READ: begin
              state_d    = ST_SETUP;
              psel_d     = 1'b1;
              pwrite_d   = 1'b0;
              inc_d      = cmd_word_q[0];
              rd_valid_d = 1'b0;
            end
            CMD_WRITE: begin
              state_d = ST_WAIT_WDATA;
              inc_d   = cmd_word_q[0];
            end
            CMD_GET_RDATA: sel_rdata_d = 1'b1;
            CMD_CLR_ERR: begin
              err_slv_d  = 1'b0;
              err_cmd_d  = 1'b0;
              err_tmo_d  = 1'b0;
              rd_valid_d = 1'b0;
            end
            default: err_cmd_d = 1'b1;
          endcase
        end
      end
      ST_WAIT_WDATA: begin
        if (ev_q) begin
          state_d  = ST_SETUP;
          pwdata_d = cmd_word_q;
          pwrite_d = 1'b1;
          psel_d   = 1'b1;
        end else if (bus.ir_valid_i && bus.ir_i != IR_DEBUG) begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (ev_q && cmd != CMD_NOP) err_cmd_d = 1'b1;
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ST_ACCESS: begin
        if (ev_q && cmd != CMD_NOP) err_cmd_d = 1'b1;
        if (bus.pready_i) begin
          if (!pwrite_q) begin
            rdata_d    = bus.prdata_i;
            rd_valid_d = 1'b1;
          end
          if (bus.pslverr_i) err_slv_d = 1'b1;
          if (inc_q) addr_d = addr_q + ADDR_WIDTH'(4);
          state_d   = ST_IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          err_tmo_d = 1'b1;
          state_d   = ST_IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge trst_sync) begin
    if (!trst_sync) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rdata_q     <= '0;
      pwdata_q    <= '0;
      cmd_word_q  <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      inc_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      sel_rdata_q <= 1'b0;
      err_slv_q   <= 1'b0;
      err_cmd_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      ev_prev_q   <= 1'b0;
      ev_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rdata_q     <= rdata_d;
      pwdata_q    <= pwdata_d;
      cmd_word_q  <= cmd_word_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      inc_q       <= inc_d;
      rd_valid_q  <= rd_valid_d;
      sel_rdata_q <= sel_rdata_d;
      err_slv_q   <= err_slv_d;
      err_cmd_q   <= err_cmd_d;
      err_tmo_q   <= err_tmo_d;
      ev_prev_q   <= ev_prev_d;
      ev_q        <= ev_d;
    end
  end

  always_comb begin
    status                          = '0;
    status[STAT_BUSY]               = (state_q != ST_IDLE);
    status[STAT_RD_VALID]           = rd_valid_q;
    status[STAT_ERR_SLV]            = err_slv_q;
    status[STAT_ERR_CMD]            = err_cmd_q;
    status[STAT_ERR_TMO]            = err_tmo_q;
    status[STAT_FSM_LSB +: 2]       = state_q;
    status[STAT_PEND_WR]            = (state_q == ST_WAIT_WDATA);
  end

  assign bus.dr_in_o   = sel_rdata_q ? rdata_q : status;
  assign bus.psel_o    = psel_q;
  assign bus.penable_o = penable_q;
  assign bus.pwrite_o  = pwrite_q;
  assign bus.paddr_o   = addr_q;
  assign bus.pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_jtag_dbg_apb_bridge.sv
// tb/tb_jtag_dbg_apb_bridge.sv - self-checking bench for jtag_dbg_apb_bridge
module tb_jtag_dbg_apb_bridge;

  logic clk = 1'b0;
  logic trst_sync;
  always #5 clk = ~clk;

  jtag_dbg_apb_bridge_if #(.IR_WIDTH(5), .ADDR_WIDTH(16)) bus ();

  jtag_dbg_apb_bridge #(
    .IR_WIDTH(5), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .trst_sync(trst_sync), .bus(bus.master)
  );

  int n_cmp = 0;
  int n_err = 0;

  // APB slave behaviour knobs and bus monitor
  int          slv_waits = 0;
  bit          slv_never = 1'b0;
  bit          slv_err   = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  int          acc_cnt;
  int          apb_count  = 0;
  int          pen_cycles = 0;
  logic [15:0] last_addr;
  logic        last_write;
  logic [31:0] last_wdata;
  bit          wdata_moved = 1'b0;

  always @(negedge clk) begin
    if (!trst_sync) begin
      acc_cnt       = 0;
      bus.pready_i  = 1'b0;
      bus.pslverr_i = 1'b0;
      bus.prdata_i  = 32'h0;
    end else begin
      if (bus.psel_o && !bus.penable_o) begin
        apb_count++;
        last_addr  = bus.paddr_o;
        last_write = bus.pwrite_o;
        last_wdata = bus.pwdata_o;
        acc_cnt    = 0;
      end
      if (bus.psel_o && bus.penable_o) begin
        pen_cycles++;
        if (last_write && bus.pwdata_o !== last_wdata) wdata_moved = 1'b1;
        bus.pready_i  = !slv_never && (acc_cnt == slv_waits);
        bus.pslverr_i = slv_err && bus.pready_i;
        bus.prdata_i  = slv_rdata;
        acc_cnt++;
      end else begin
        bus.pready_i  = 1'b0;
        bus.pslverr_i = 1'b0;
      end
    end
  end

  // Reference model: what the bridge should report, tracked per command
  logic [15:0] exp_addr;
  logic [31:0] exp_rdata;
  bit exp_rdv, exp_slv, exp_cmd, exp_tmo, exp_sel;

  function automatic logic [31:0] model_status(bit busy, bit [1:0] fsm, bit pw);
    return {busy, exp_rdv, exp_slv, exp_cmd, exp_tmo, 24'h0, fsm, pw};
  endfunction

  task automatic model_reset();
    exp_addr = 16'h0; exp_rdata = 32'h0;
    exp_rdv = 0; exp_slv = 0; exp_cmd = 0; exp_tmo = 0; exp_sel = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check(tag, bus.dr_in_o, exp_sel ? exp_rdata : model_status(0, 2'b00, 0));
  endtask

  task automatic scan(input logic [31:0] w);
    @(negedge clk);
    bus.dr_i = w; bus.dr_valid_i = 1'b1; bus.dr_done_i = 1'b1;
    @(negedge clk);
    bus.dr_done_i = 1'b0;
    exp_sel = 1'b0;
  endtask

  task automatic settle(input string tag);
    int n = 0;
    @(negedge clk); @(negedge clk);
    while ((bus.psel_o || bus.penable_o) && n < 200) begin
      @(negedge clk); n++;
    end
    check({tag, "_settle"}, {31'h0, bus.psel_o}, 32'h0);
    @(negedge clk);
  endtask

  task automatic do_read(input string tag, input bit inc, input int waits,
                         input logic [31:0] data, input bit err);
    int c0 = apb_count;
    slv_waits = waits; slv_rdata = data; slv_err = err;
    scan({4'h2, 27'h0, inc});
    settle(tag);
    check({tag, "_count"}, apb_count - c0, 1);
    check({tag, "_addr"}, {16'h0, last_addr}, {16'h0, exp_addr});
    check({tag, "_dir"}, {31'h0, last_write}, 32'h0);
    exp_rdv = 1; exp_rdata = data;
    if (err) exp_slv = 1;
    if (inc) exp_addr = exp_addr + 16'd4;
    slv_err = 0;
  endtask

  task automatic do_write(input string tag, input bit inc, input int waits,
                          input logic [31:0] data, input bit err);
    int c0 = apb_count;
    slv_waits = waits; slv_err = err;
    scan({4'h3, 27'h0, inc});
    settle(tag);
    check({tag, "_armed"}, bus.dr_in_o, model_status(1, 2'b01, 1));
    scan(data);
    settle(tag);
    check({tag, "_count"}, apb_count - c0, 1);
    check({tag, "_addr"}, {16'h0, last_addr}, {16'h0, exp_addr});
    check({tag, "_dir"}, {31'h0, last_write}, 32'h1);
    check({tag, "_wdata"}, last_wdata, data);
    if (err) exp_slv = 1;
    if (inc) exp_addr = exp_addr + 16'd4;
    slv_err = 0;
  endtask

  initial begin
    int c0;
    int p0;
    logic [31:0] r;
    logic [3:0]  op;
    trst_sync      = 1'b0;
    bus.ir_i       = 5'h12;
    bus.ir_valid_i = 1'b0;
    bus.dr_i       = 32'h0;
    bus.dr_valid_i = 1'b0;
    bus.dr_done_i  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    trst_sync = 1'b1;
    @(negedge clk);
    check("reset_dr_in", bus.dr_in_o, 32'h0);
    check("reset_psel", {31'h0, bus.psel_o}, 32'h0);
    check("reset_penable", {31'h0, bus.penable_o}, 32'h0);
    check("reset_paddr", {16'h0, bus.paddr_o}, 32'h0);

    // SET_ADDR then READ with exact latency on the bus
    scan({4'h1, 28'h4000100});
    exp_addr = 16'h0400;
    settle("set_addr");
    slv_waits = 0; slv_rdata = 32'hCAFEF00D;
    c0 = apb_count;
    scan(32'h2000_0001);
    check("rd_lat_psel_early", {31'h0, bus.psel_o}, 32'h0);
    @(negedge clk);
    check("rd_lat_psel", {31'h0, bus.psel_o}, 32'h1);
    check("rd_lat_penable_setup", {31'h0, bus.penable_o}, 32'h0);
    check("rd_paddr", {16'h0, bus.paddr_o}, 32'h0400);
    @(negedge clk);
    check("rd_lat_penable", {31'h0, bus.penable_o}, 32'h1);
    settle("rd1");
    check("rd1_count", apb_count - c0, 1);
    exp_rdv = 1; exp_rdata = 32'hCAFEF00D; exp_addr = 16'h0404;
    check("rd1_status", bus.dr_in_o, 32'h4000_0000);
    scan(32'h4000_0000);
    settle("get_rdata");
    exp_sel = 1;
    check("get_rdata", bus.dr_in_o, 32'hCAFEF00D);
    scan(32'h0);
    settle("nop_clears_sel");
    check("sel_cleared", bus.dr_in_o, 32'h4000_0000);
    check("addr_after_inc", {16'h0, exp_addr}, {16'h0, bus.paddr_o});

    // WRITE with three wait states, checked mid-transfer
    slv_waits = 3;
    scan(32'h3000_0000);
    settle("wr_arm");
    check("wr_armed_status", bus.dr_in_o, 32'hC000_0003);
    scan(32'hDEADBEEF);
    @(negedge clk);
    check("wr_pwrite", {31'h0, bus.pwrite_o}, 32'h1);
    @(negedge clk);
    check("wr_penable", {31'h0, bus.penable_o}, 32'h1);
    check("wr_pwdata", bus.pwdata_o, 32'hDEADBEEF);
    check("wr_busy", {31'h0, bus.dr_in_o[31]}, 32'h1);
    settle("wr1");
    check("wr_idle_status", bus.dr_in_o, 32'h4000_0000);
    check("wr_last_wdata", last_wdata, 32'hDEADBEEF);

    // Timeout: penable stays high for exactly 16 cycles
    slv_never = 1;
    p0 = pen_cycles;
    scan(32'h2000_0001);
    settle("tmo");
    check("tmo_pen_cycles", pen_cycles - p0, 16);
    exp_rdv = 0; exp_tmo = 1;
    check("tmo_status", bus.dr_in_o, 32'h0800_0000);
    slv_never = 0;
    scan(32'h5000_0000);
    settle("clr_err");
    exp_tmo = 0;
    check("clr_err_status", bus.dr_in_o, 32'h0);
    do_read("rd_after_tmo", 0, 0, 32'h1234_5678, 0);

    // Commands while busy: READ and illegal 0x9 during an in-flight read
    slv_waits = 4; slv_rdata = 32'hA5A5_0F0F;
    c0 = apb_count;
    scan(32'h2000_0000);
    scan(32'h2000_0000);
    scan(32'h9000_0000);
    settle("busy");
    check("busy_one_pulse", apb_count - c0, 1);
    exp_rdv = 1; exp_rdata = 32'hA5A5_0F0F; exp_cmd = 1;
    check("busy_status", bus.dr_in_o, 32'h5000_0000);
    scan(32'h5000_0000);
    settle("clr2");
    exp_rdv = 0; exp_cmd = 0;

    // Address wraps modulo 2^16
    scan({4'h1, 28'h0003FFF});
    exp_addr = 16'hFFFC;
    settle("wrap_set");
    do_read("wrap_rd", 1, 0, 32'h0BAD_CAFE, 0);
    check("wrap_addr", {16'h0, exp_addr}, 32'h0);
    do_read("wrap_rd2", 0, 0, 32'h1111_2222, 0);

    // WRITE armed, then IR changes away from DEBUG
    c0 = apb_count;
    scan(32'h3000_0000);
    settle("ir_abort_arm");
    @(negedge clk);
    bus.ir_i = 5'h01; bus.ir_valid_i = 1'b1;
    @(negedge clk);
    bus.ir_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("ir_abort_status", bus.dr_in_o, model_status(0, 2'b00, 0));
    check("ir_abort_no_apb", apb_count - c0, 0);
    bus.ir_i = 5'h12;

    // Randomized command mix against the model
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 6));
      r  = $urandom;
      case (op)
        4'd0: begin scan(32'h0); settle("rnd_nop"); end
        4'd1: begin
          scan({4'h1, r[27:0]});
          exp_addr = {r[13:0], 2'b00};
          settle("rnd_set");
        end
        4'd2: do_read("rnd_rd", r[0], $urandom_range(0, 3), $urandom, ($urandom_range(0, 3) == 0));
        4'd3: do_write("rnd_wr", r[0], $urandom_range(0, 3), $urandom, ($urandom_range(0, 3) == 0));
        4'd4: begin scan(32'h4000_0000); settle("rnd_get"); exp_sel = 1; end
        4'd5: begin
          scan(32'h5000_0000); settle("rnd_clr");
          exp_rdv = 0; exp_slv = 0; exp_cmd = 0; exp_tmo = 0;
        end
        default: begin
          scan({4'($urandom_range(6, 15)), r[27:0]});
          settle("rnd_bad");
          exp_cmd = 1;
        end
      endcase
      check_status("rnd_status");
    end
    check("wdata_held", {31'h0, wdata_moved}, 32'h0);

    // Reset in the middle of ACCESS
    slv_never = 1;
    scan(32'h2000_0000);
    @(negedge clk); @(negedge clk);
    check("rst_in_access", {31'h0, bus.penable_o}, 32'h1);
    trst_sync = 1'b0;
    #1;
    check("rst_psel", {31'h0, bus.psel_o}, 32'h0);
    check("rst_penable", {31'h0, bus.penable_o}, 32'h0);
    check("rst_dr_in", bus.dr_in_o, 32'h0);
    @(negedge clk);
    trst_sync = 1'b1;
    slv_never = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_status("rst_release_status");
    check("rst_release_paddr", {16'h0, bus.paddr_o}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
